// File: rtl/imem_stream_loader_pkg.sv
// Shared types and field-packing constants for the instruction memory loader.
// Field order runs from the opcode-like top field down to the lowest nibble.
package imem_pkg;

  localparam int NUM_FIELDS = 7;

  localparam int FW0 = 6, FW1 = 5, FW2 = 5, FW3 = 5, FW4 = 3, FW5 = 4, FW6 = 4;
  localparam int FS0 = 26, FS1 = 21, FS2 = 16, FS3 = 11, FS4 = 8, FS5 = 4, FS6 = 0;

  typedef enum logic {
    LOAD = 1'b0,
    DONE = 1'b1
  } state_e;

  // Mask the low bits of a field beat and move them to their slot in the word.
  function automatic logic [31:0] pack_field(input logic [2:0] idx, input logic [31:0] data);
    int w;
    int s;
    w = 0;
    s = 0;
    case (idx)
      3'd0: begin w = FW0; s = FS0; end
      3'd1: begin w = FW1; s = FS1; end
      3'd2: begin w = FW2; s = FS2; end
      3'd3: begin w = FW3; s = FS3; end
      3'd4: begin w = FW4; s = FS4; end
      3'd5: begin w = FW5; s = FS5; end
      3'd6: begin w = FW6; s = FS6; end
      default: begin w = 0; s = 0; end
    endcase
    return (data & ((32'd1 << w) - 32'd1)) << s;
  endfunction

endpackage

// File: rtl/imem_stream_loader_if.sv
// Loader stream, fetch read port and status signals of the instruction memory.
// Handshake: a loader beat transfers on a rising edge where ld_valid & ld_ready are both high.
interface imem_stream_loader_if #(parameter int AW = 4);
  logic          ld_valid;
  logic          ld_ready;
  logic [31:0]   ld_data;
  logic          ld_raw;
  logic          ld_last;
  logic          ld_restart;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic [AW:0]   prog_len;
  logic          loaded;
  logic          err_overflow;

  modport master (
    output ld_valid, ld_data, ld_raw, ld_last, ld_restart, rd_en, rd_addr,
    input  ld_ready, rd_data, rd_valid, prog_len, loaded, err_overflow
  );

  modport slave (
    input  ld_valid, ld_data, ld_raw, ld_last, ld_restart, rd_en, rd_addr,
    output ld_ready, rd_data, rd_valid, prog_len, loaded, err_overflow
  );
endinterface

// File: rtl/imem_stream_loader_packer.sv
// Assembles field beats (or a single raw beat) into 32-bit instruction words.
// The raw/field mode is only honoured at field index 0, so a word never mixes modes.
module imem_word_packer
  import imem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_clear,
   input  logic        i_beat,
   input  logic [31:0] i_data,
   input  logic        i_raw,
   input  logic        i_last,
   output logic [31:0] o_word,
   output logic        o_word_done
);

   localparam logic [2:0] LAST_IDX = 3'(NUM_FIELDS - 1);

   logic [2:0]  r_idx;
   logic [31:0] r_acc;
   logic        w_raw_mode;
   logic [31:0] w_word;
   logic        w_done;

   always_comb begin
      w_raw_mode = (r_idx == 3'd0) & i_raw;
      w_word     = w_raw_mode ? i_data : (r_acc | pack_field(r_idx, i_data));
      w_done     = i_beat & (w_raw_mode | (r_idx == LAST_IDX) | i_last);
   end

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_idx <= 3'd0;
         r_acc <= 32'd0;
      end else if (i_beat) begin
         if (w_done) begin
            r_idx <= 3'd0;
            r_acc <= 32'd0;
         end else begin
            r_idx <= r_idx + 3'd1;
            r_acc <= w_word;
         end
      end
   end

   assign o_word      = w_word;
   assign o_word_done = w_done;

endmodule

// File: rtl/imem_stream_loader.sv
// Instruction memory filled sequentially from an in-band loader stream, read by fetch.
// Words at or beyond prog_len read as zero, so stale contents after a reload stay hidden.
module imem_stream_loader
  import imem_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
)(
   input  logic                 clk,
   input  logic                 reset,
   imem_stream_loader_if.slave  bus,
   output state_e               o_state
);

   state_e           r_state;
   state_e           w_next_state;
   logic [AW:0]      r_wr_ptr;
   logic             r_full;
   logic             r_err_overflow;
   logic [31:0]      r_mem [DEPTH];
   logic [31:0]      r_rd_data;
   logic             r_rd_valid;
   logic             w_accept;
   logic             w_load_beat;
   logic             w_at_end;
   logic [31:0]      w_word;
   logic             w_word_done;

   assign bus.ld_ready = ~bus.ld_restart;
   assign w_accept     = bus.ld_valid & bus.ld_ready;
   assign w_load_beat  = w_accept & (r_state == LOAD);
   assign w_at_end     = (r_wr_ptr == (AW+1)'(DEPTH - 1));

   imem_word_packer u_packer (
      .clk         (clk),
      .reset       (reset),
      .i_clear     (bus.ld_restart),
      .i_beat      (w_load_beat),
      .i_data      (bus.ld_data),
      .i_raw       (bus.ld_raw),
      .i_last      (bus.ld_last),
      .o_word      (w_word),
      .o_word_done (w_word_done)
   );

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         LOAD:    if (w_word_done && (bus.ld_last || w_at_end)) w_next_state = DONE;
         DONE:    w_next_state = DONE;
         default: w_next_state = LOAD;
      endcase
      if (bus.ld_restart) w_next_state = LOAD;
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= LOAD;
      else       r_state <= w_next_state;
   end

   // r_full tells an overflow-causing DONE apart from one reached through ld_last.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr       <= '0;
         r_full         <= 1'b0;
         r_err_overflow <= 1'b0;
      end else begin
         if (bus.ld_restart) begin
            r_wr_ptr <= '0;
            r_full   <= 1'b0;
         end else if (w_word_done) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_at_end) r_full <= 1'b1;
         end
         if ((r_state == DONE) && r_full && w_accept) r_err_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_word_done) r_mem[r_wr_ptr[AW-1:0]] <= w_word;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_data  <= 32'd0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= bus.rd_en;
         if (bus.rd_en)
            r_rd_data <= ({1'b0, bus.rd_addr} < r_wr_ptr) ? r_mem[bus.rd_addr] : 32'd0;
      end
   end

   assign bus.rd_data      = r_rd_data;
   assign bus.rd_valid     = r_rd_valid;
   assign bus.prog_len     = r_wr_ptr;
   assign bus.loaded       = (r_state == DONE);
   assign bus.err_overflow = r_err_overflow;
   assign o_state          = r_state;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: field/raw loading, read guard, overflow and restart.
module tb_imem_stream_loader;
  import imem_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic   clk;
  logic   reset;
  state_e o_state;
  int     n_cmp;
  int     n_err;
  logic [31:0] exp_q[$];

  imem_stream_loader_if #(.AW(AW)) bus ();

  imem_stream_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .o_state (o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge, outputs sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic raw, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_raw   = raw;
    bus.ld_last  = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_raw   = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic send_fields(input logic [31:0] f0, input logic [31:0] f1, input logic [31:0] f2,
                             input logic [31:0] f3, input logic [31:0] f4, input logic [31:0] f5,
                             input logic [31:0] f6);
    logic [31:0] f[7];
    f = '{f0, f1, f2, f3, f4, f5, f6};
    for (int i = 0; i < 7; i++) send_beat(f[i], 1'b0, 1'b0);
  endtask

  task automatic restart();
    bus.ld_restart = 1'b1;
    tick();
    bus.ld_restart = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [31:0] exp, input string tag);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    tick();
    bus.rd_en = 1'b0;
    check_val({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    check_val(tag, bus.rd_data, exp);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.ld_valid   = 1'b0;
    bus.ld_data    = 32'd0;
    bus.ld_raw     = 1'b0;
    bus.ld_last    = 1'b0;
    bus.ld_restart = 1'b0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    apply_reset();

    check_val("rst_prog_len", 32'(bus.prog_len), 32'd0);
    check_val("rst_loaded", 32'(bus.loaded), 32'd0);
    check_val("rst_err", 32'(bus.err_overflow), 32'd0);
    check_val("rst_rd_data", bus.rd_data, 32'd0);
    check_val("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check_val("rst_ready", 32'(bus.ld_ready), 32'd1);
    check_val("rst_state", 32'(o_state), 32'(LOAD));

    // field word: 0<<26 | 1<<21 | 2<<16 | 3<<11 | 0<<8 | 2<<4 | 0
    send_fields(32'h00, 32'h01, 32'h02, 32'h03, 32'h0, 32'h2, 32'h0);
    check_val("f1_prog_len", 32'(bus.prog_len), 32'd1);
    check_val("f1_loaded", 32'(bus.loaded), 32'd0);
    do_read(4'd0, 32'h0022_1820, "f1_rd0");

    // masking of the top field
    send_fields(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    check_val("mask_prog_len", 32'(bus.prog_len), 32'd2);
    do_read(4'd1, 32'hFC00_0000, "mask_rd1");
    tick();
    check_val("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
    check_val("idle_rd_hold", bus.rd_data, 32'hFC00_0000);

    // three raw words, ld_last on the third
    restart();
    check_val("rs_prog_len", 32'(bus.prog_len), 32'd0);
    do_read(4'd0, 32'd0, "rs_rd0_hidden");
    send_beat(32'hDEAD_BEEF, 1'b1, 1'b0);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 4'd1;
    send_beat(32'h1234_5678, 1'b1, 1'b0);
    bus.rd_en = 1'b0;
    check_val("same_cycle_rd", bus.rd_data, 32'd0);
    do_read(4'd1, 32'h1234_5678, "next_cycle_rd1");
    send_beat(32'hCAFE_F00D, 1'b1, 1'b1);
    check_val("raw_prog_len", 32'(bus.prog_len), 32'd3);
    check_val("raw_loaded", 32'(bus.loaded), 32'd1);
    check_val("raw_state", 32'(o_state), 32'(DONE));
    do_read(4'd3, 32'd0, "raw_rd3");
    do_read(4'd2, 32'hCAFE_F00D, "raw_rd2");
    do_read(4'd0, 32'hDEAD_BEEF, "raw_rd0");
    send_beat(32'h5555_5555, 1'b1, 1'b0);
    check_val("after_last_err", 32'(bus.err_overflow), 32'd0);
    check_val("after_last_len", 32'(bus.prog_len), 32'd3);

    // ld_last mid-word: partial word with remaining fields zero
    restart();
    send_beat(32'h23, 1'b0, 1'b0);
    send_beat(32'h05, 1'b0, 1'b1);
    check_val("part_prog_len", 32'(bus.prog_len), 32'd1);
    check_val("part_loaded", 32'(bus.loaded), 32'd1);
    do_read(4'd0, 32'h8CA0_0000, "part_rd0");

    // fill the memory with raw words, then one more beat overflows
    restart();
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(32'hA500_0000 + 32'(i * 3));
      send_beat(32'hA500_0000 + 32'(i * 3), 1'b1, 1'b0);
      if (i == DEPTH - 2) check_val("fill_not_loaded", 32'(bus.loaded), 32'd0);
    end
    check_val("full_loaded", 32'(bus.loaded), 32'd1);
    check_val("full_prog_len", 32'(bus.prog_len), 32'd16);
    check_val("full_err_before", 32'(bus.err_overflow), 32'd0);
    check_val("full_ready", 32'(bus.ld_ready), 32'd1);
    send_beat(32'h0BAD_0BAD, 1'b1, 1'b0);
    check_val("ovf_err", 32'(bus.err_overflow), 32'd1);
    check_val("ovf_prog_len", 32'(bus.prog_len), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      do_read(AW'(i), e, "full_rd");
    end

    // restart keeps err_overflow; beat in the restart cycle is refused
    restart();
    check_val("rs2_err_kept", 32'(bus.err_overflow), 32'd1);
    check_val("rs2_loaded", 32'(bus.loaded), 32'd0);
    for (int i = 0; i < 5; i++) send_beat(32'h7000_0000 + 32'(i), 1'b1, 1'b0);
    check_val("five_prog_len", 32'(bus.prog_len), 32'd5);
    bus.ld_restart = 1'b1;
    bus.ld_valid   = 1'b1;
    bus.ld_raw     = 1'b1;
    bus.ld_data    = 32'h1111_1111;
    #1;
    check_val("rs_ready_low", 32'(bus.ld_ready), 32'd0);
    tick();
    bus.ld_restart = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_raw     = 1'b0;
    check_val("rsv_prog_len", 32'(bus.prog_len), 32'd0);
    check_val("rsv_err_kept", 32'(bus.err_overflow), 32'd1);
    tick();
    check_val("rsv_no_write", 32'(bus.prog_len), 32'd0);

    // partial word dropped by restart, then a clean field word
    send_beat(32'h3F, 1'b0, 1'b0);
    send_beat(32'h1F, 1'b0, 1'b0);
    send_beat(32'h1F, 1'b0, 1'b0);
    restart();
    send_fields(32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7);
    check_val("clean_prog_len", 32'(bus.prog_len), 32'd1);
    do_read(4'd0, 32'h0443_2567, "clean_rd0");

    // synchronous reset mid-word behaves the same and clears err_overflow
    send_beat(32'h3F, 1'b0, 1'b0);
    send_beat(32'h1F, 1'b0, 1'b0);
    apply_reset();
    check_val("rst2_err", 32'(bus.err_overflow), 32'd0);
    check_val("rst2_prog_len", 32'(bus.prog_len), 32'd0);
    send_fields(32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7);
    do_read(4'd0, 32'h0443_2567, "rst2_rd0");
    do_read(4'd1, 32'd0, "rst2_rd1_hidden");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
